// File: rtl/fetch_queue.sv
// Instruction fetch stage: sequential imem requests into a small prefetch
// queue, with redirect/flush handling and tagged fetch faults for decode.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_fault,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_funct3,
    output logic [6:0]      id_funct7,
    output logic [11:0]     id_funct12,
    output logic            id_fetch_fault,
    output logic [3:0]      id_excep_code
);

    localparam int PW = (QDEPTH > 2) ? 2 : 1;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_FETCH,
        S_FLUSH,
        S_MISAL,
        S_HALT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] hold_addr;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    logic [XLEN-1:0] pc_q    [QDEPTH];
    logic [XLEN-1:0] instr_q [QDEPTH];
    logic            fault_q [QDEPTH];
    logic            code_q  [QDEPTH];

    logic            req;
    logic            done;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] push_instr;
    logic            push_fault;
    logic            push_code;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign req       = (state == S_FLUSH)
                    || (state == S_FETCH && count < CW'(QDEPTH));
    assign done      = req && imem_ack;
    assign imem_req  = req;
    assign imem_addr = (state == S_FLUSH) ? hold_addr : fetch_pc;

    assign id_valid = (count != '0);
    assign pop      = id_valid && id_ready && !redirect;

    always_comb begin
        state_nxt  = state;
        push       = 1'b0;
        push_instr = NOP;
        push_fault = 1'b0;
        push_code  = 1'b0;
        if (redirect) begin
            // an unacked request must still be drained before refetching
            if (req && !imem_ack)
                state_nxt = S_FLUSH;
            else if (redirect_pc[1:0] != 2'b00)
                state_nxt = S_MISAL;
            else
                state_nxt = S_FETCH;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (done) begin
                        push = 1'b1;
                        if (imem_fault) begin
                            push_fault = 1'b1;
                            push_code  = 1'b1;
                            state_nxt  = S_HALT;
                        end else begin
                            push_instr = imem_rdata;
                        end
                    end
                end
                S_FLUSH: begin
                    if (imem_ack)
                        state_nxt = (fetch_pc[1:0] != 2'b00) ? S_MISAL : S_FETCH;
                end
                S_MISAL: begin
                    push       = 1'b1;
                    push_fault = 1'b1;
                    state_nxt  = S_HALT;
                end
                S_HALT: begin
                    state_nxt = S_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            fetch_pc  <= RESET_PC;
            hold_addr <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            state <= state_nxt;
            if (redirect)
                fetch_pc <= redirect_pc;
            else if (state == S_FETCH && done && !imem_fault)
                fetch_pc <= fetch_pc + XLEN'(4);
            if (redirect && state != S_FLUSH)
                hold_addr <= fetch_pc;
            if (redirect) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push)
                    tail <= ptr_inc(tail);
                if (pop)
                    head <= ptr_inc(head);
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !redirect) begin
            pc_q[tail]    <= fetch_pc;
            instr_q[tail] <= push_instr;
            fault_q[tail] <= push_fault;
            code_q[tail]  <= push_code;
        end
    end

    assign id_instr       = id_valid ? instr_q[head] : NOP;
    assign id_pc          = id_valid ? pc_q[head] : '0;
    assign id_fetch_fault = id_valid && fault_q[head];
    assign id_excep_code  = {3'b000, id_valid && code_q[head]};

    assign id_opcode  = id_instr[6:0];
    assign id_funct3  = id_instr[14:12];
    assign id_funct7  = id_instr[31:25];
    assign id_funct12 = id_instr[31:20];

endmodule
